regfile_multiport: RTL

Parametrised successor of the core's integer register file. It provides a configurable number of combinational read ports, one synchronous write port, optional write-to-read bypass and a hardwired-zero entry. It adds a per-entry pending-write scoreboard and a hardware clear sequencer that zeroes the array after reset or on request. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy.

---
 rtl/regfile_multiport.sv | 126 ++++++++++++
 1 files changed

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with clear sequencer and busy scoreboard.
// Reads are combinational; one synchronous write port with optional bypass.
module regfile_multiport #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  init_done,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  busy_set_en,
  input  logic [AW-1:0]         busy_set_addr
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam logic ZERO = (ZERO_REG != 0);
  localparam logic BYP  = (BYPASS != 0);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_q;

  logic ready;
  logic clr_go;
  logic wr_ok;
  logic set_ok;

  assign ready     = (state_q == READY);
  assign init_done = ready;
  assign clr_go    = ready & clear_req;

  // A write alongside clear_req is discarded with the rest of the array.
  assign wr_ok  = ready & wr_en & ~clear_req
                & ~(ZERO & (wr_addr == '0));
  assign set_ok = ready & busy_set_en & ~clear_req
                & ~(ZERO & (busy_set_addr == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Set is applied after clear so a new producer wins over writeback.
  always_ff @(posedge clk) begin
    if (reset || clr_go) begin
      busy_q <= '0;
    end else begin
      if (wr_ok)
        busy_q[wr_addr] <= 1'b0;
      if (set_ok)
        busy_q[busy_set_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!ready)
        mem[cnt_q] <= '0;
      else if (wr_ok)
        mem[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zhit;
    logic          bhit;

    assign ra   = rd_addr[g*AW +: AW];
    assign zhit = ZERO & (ra == '0);
    assign bhit = BYP & wr_ok & (wr_addr == ra);

    assign rd_data[g*XLEN +: XLEN] =
      (!ready || zhit) ? '0      :
      bhit             ? wr_data :
                         mem[ra];

    assign rd_busy[g] = ready & busy_q[ra];
  end

endmodule
